decoder_onehot_seq: RTL and testbench
=====================================

// Module: decoder_onehot_seq
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder. It generalises the fixed 2-to-4 decoder to SEL_W-to-2^SEL_W.
//  Also adds free-running and single-pass scan modes for strobing chip-selects, display digits and row drivers.
//  Sits between control logic and any one-hot select fabric; every output is registered.
// PARAMETERS
//  SEL_W     2  select width; OUT_W = 2**SEL_W (localparam, not overridable)
//  SCAN_DIV  4  clock cycles each index is held in scan modes (>=1)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      reset: asynchronous assert, active-low
//  en     in   1      clock enable; low freezes all state and outputs
//  mode   in   2      00 IDLE, 01 DECODE, 10 SCAN (cyclic), 11 ONESHOT (single pass)
//  sel    in   SEL_W  decode select (DECODE); start index (SCAN/ONESHOT entry)
//  d      out  OUT_W  one-hot output; all-zero when inactive
//  idx    out  SEL_W  binary index of the asserted d bit
//  valid  out  1      high while d is one-hot
//  wrap   out  1      1-cycle pulse when SCAN steps OUT_W-1 -> 0
//  done   out  1      high after ONESHOT finishes; held until mode changes
// BEHAVIOUR
//  Reset: d=0, idx=0, valid=0, wrap=0, done=0, state=S_IDLE, prescaler=0.
//  Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for clk.
//  FSM states: S_IDLE, S_DEC, S_SCAN, S_ONE, S_DONE. Evaluated only on cycles with en=1.
//  Mode change: the next state follows mode on the next edge. Entry into S_SCAN or S_ONE:
//   - idx <= sel, prescaler <= 0, d <= 1<<sel, valid <= 1, done <= 0.
//  S_IDLE: d=0, valid=0, idx holds its last value.
//  S_DEC: d <= 1<<sel and idx <= sel every enabled cycle. Latency 1 clk. valid=1.
//  S_SCAN: prescaler counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1:
//   - prescaler -> 0 and idx -> idx+1 mod OUT_W; d follows idx.
//   - wrap=1 on the same edge that idx goes OUT_W-1 -> 0; otherwise wrap=0.
//  S_ONE: stepping is the same as S_SCAN. At the end of the dwell on idx=OUT_W-1, go to S_DONE: d=0, valid=0, done=1.
//   - Starting at sel=OUT_W-1 gives a single dwell.
//  S_DONE: stays until mode != 11. Leaving to DECODE or IDLE clears done on that edge.
//   - Retrigger: mode must pass through another value first; mode=11 held in S_DONE does not restart.
//  SCAN_DIV=1: idx advances every enabled cycle. The prescaler is absent/constant.
//  en=0: prescaler, idx, d, state and done all hold. wrap is forced 0 (no stretched pulse).
//   - A mode change during en=0 is taken on the first enabled edge.
//  Invariant: valid=1 <=> d==(1<<idx); d is never multi-hot.
//  Widths: idx increment is modulo 2^SEL_W by natural overflow. Prescaler width is $clog2(SCAN_DIV), minimum 1.
// STRUCTURE
//  Package decoder_pkg: mode encodings (MODE_IDLE/DEC/SCAN/ONE), FSM state typedef, onehot(sel) function.
//  Sub-module decoder_tick_gen: SCAN_DIV prescaler with en, clear and tick outputs.
//  FSM, index register and output registers live in the top module.
// TESTING
//  SEL_W=2: reset, then DECODE with sel=2 -> next edge d=4'b0100, idx=2, valid=1.
//   - Sweep sel 0..3 -> d 0001, 0010, 0100, 1000, each one cycle later.
//  SCAN, SCAN_DIV=4, sel=1 -> d=0010 for 4 clks, then 0100, 1000, 0001.
//   - wrap pulses exactly once, on the 1000 -> 0001 edge; period 16 clks.
//  ONESHOT, sel=0, SCAN_DIV=2 -> 8 clks of scan, then d=0, valid=0, done=1.
//   - Holding mode=11 keeps done=1; IDLE then 11 again restarts.
//  Freeze and reset: en=0 for 5 clks mid-SCAN -> d and idx unchanged, wrap=0.
//   - rst_n low mid-scan -> d=0 and valid=0 asynchronously, before the next clk.
//  SEL_W=3, SCAN_DIV=1, SCAN -> d walks 8 one-hot codes per cycle, wrap every 8th clk.
//   - Assert valid <=> d==(1<<idx) on every cycle.

Source files
------------

// File: rtl/decoder_onehot_seq_pkg.sv
// Shared mode encodings, FSM state type and the one-hot helper for the
// registered binary-to-one-hot decoder.
package decoder_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_SCAN = 2'b10;
    localparam logic [1:0] MODE_ONE  = 2'b11;

    // Widest select the helper supports; callers truncate to their own width.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_SCAN,
        S_ONE,
        S_DONE
    } state_t;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] s);
        logic [MAX_OUT_W-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_onehot_seq_tick_gen.sv
// Dwell prescaler: counts 0..SCAN_DIV-1 while enabled and flags the last count.
// With SCAN_DIV=1 the counter stays at zero and every enabled cycle is a tick.
module decoder_tick_gen #(
    parameter int SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == PRE_LAST) ? '0 : cnt_reg + PRE_W'(1);
        end
    end

    assign tick = en && !clear && (cnt_reg == PRE_LAST);

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct decode, cyclic scan
// and single-pass scan modes. All outputs come straight from flops.
module decoder_onehot_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] d,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap,
    output logic                  done
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_LAST = '1;

    function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] s);
        return OUT_W'(onehot(MAX_SEL_W'(s)));
    endfunction

    state_t            state_reg, state_next;
    logic [OUT_W-1:0]  d_reg, d_next;
    logic [SEL_W-1:0]  idx_reg, idx_next;
    logic              valid_reg, valid_next;
    logic              wrap_reg, wrap_next;
    logic              done_reg, done_next;
    logic              pre_run, pre_clear, tick;

    // Prescaler runs only while already dwelling; it is cleared on scan entry.
    assign pre_run   = en && (((state_reg == S_SCAN) && (mode == MODE_SCAN)) ||
                              ((state_reg == S_ONE)  && (mode == MODE_ONE)));
    assign pre_clear = en && (((mode == MODE_SCAN) && (state_reg != S_SCAN)) ||
                              ((mode == MODE_ONE) && (state_reg != S_ONE) &&
                               (state_reg != S_DONE)));

    decoder_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_run),
        .clear (pre_clear),
        .tick  (tick)
    );

    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        done_next  = done_reg;
        wrap_next  = 1'b0;
        if (en) begin
            case (mode)
                MODE_IDLE: begin
                    state_next = S_IDLE;
                    d_next     = '0;
                    valid_next = 1'b0;
                    done_next  = 1'b0;
                end
                MODE_DEC: begin
                    state_next = S_DEC;
                    d_next     = dec(sel);
                    idx_next   = sel;
                    valid_next = 1'b1;
                    done_next  = 1'b0;
                end
                MODE_SCAN: begin
                    if (state_reg != S_SCAN) begin
                        state_next = S_SCAN;
                        d_next     = dec(sel);
                        idx_next   = sel;
                        valid_next = 1'b1;
                        done_next  = 1'b0;
                    end else if (tick) begin
                        idx_next  = idx_reg + SEL_W'(1);
                        d_next    = dec(idx_reg + SEL_W'(1));
                        wrap_next = (idx_reg == IDX_LAST);
                    end
                end
                default: begin
                    // Single pass; S_DONE stays put until mode leaves ONESHOT.
                    if (state_reg == S_ONE) begin
                        if (tick) begin
                            if (idx_reg == IDX_LAST) begin
                                state_next = S_DONE;
                                d_next     = '0;
                                valid_next = 1'b0;
                                done_next  = 1'b1;
                            end else begin
                                idx_next = idx_reg + SEL_W'(1);
                                d_next   = dec(idx_reg + SEL_W'(1));
                            end
                        end
                    end else if (state_reg != S_DONE) begin
                        state_next = S_ONE;
                        d_next     = dec(sel);
                        idx_next   = sel;
                        valid_next = 1'b1;
                        done_next  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            d_reg     <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            d_reg     <= d_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
            wrap_reg  <= wrap_next;
            done_reg  <= done_next;
        end
    end

    assign d     = d_reg;
    assign idx   = idx_reg;
    assign valid = valid_reg;
    assign wrap  = wrap_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed bench: decode, cyclic scan, one-shot, freeze, async reset and a
// 3-bit single-cycle-dwell scan, each compared against hand-computed values.
module tb_decoder_onehot_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode_a, mode_b, mode_c;
    logic [1:0] sel_a, sel_b;
    logic [2:0] sel_c;

    logic [3:0] d_a, d_b;
    logic [7:0] d_c;
    logic [1:0] idx_a, idx_b;
    logic [2:0] idx_c;
    logic       valid_a, valid_b, valid_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       done_a, done_b, done_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] d_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    decoder_onehot_seq #(.SEL_W(2), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_a), .sel(sel_a),
        .d(d_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a), .done(done_a));

    decoder_onehot_seq #(.SEL_W(2), .SCAN_DIV(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_b), .sel(sel_b),
        .d(d_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b), .done(done_b));

    decoder_onehot_seq #(.SEL_W(3), .SCAN_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_c), .sel(sel_c),
        .d(d_c), .idx(idx_c), .valid(valid_c), .wrap(wrap_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        mode_a = 2'b00; mode_b = 2'b00; mode_c = 2'b00;
        sel_a  = 2'd0;  sel_b  = 2'd0;  sel_c  = 3'd0;
        step(); step();
        chk("rst_d",     d_a, 4'b0000);
        chk("rst_idx",   idx_a, 2'd0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_wrap",  wrap_a, 1'b0);
        chk("rst_done",  done_a, 1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_d", d_a, 4'b0000);

        // DECODE sel=2
        mode_a = 2'b01; sel_a = 2'd2;
        step();
        chk("dec2_d",     d_a, 4'b0100);
        chk("dec2_idx",   idx_a, 2'd2);
        chk("dec2_valid", valid_a, 1'b1);
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            step();
            chk($sformatf("sweep%0d_d", s), d_a, d_tab[s]);
            chk($sformatf("sweep%0d_idx", s), idx_a, 32'(s));
        end

        // SCAN from sel=1, 4-cycle dwell
        mode_a = 2'b10; sel_a = 2'd1;
        step();
        for (int k = 0; k <= 28; k++) begin
            if (k > 0) step();
            chk($sformatf("scan%0d_d", k), d_a, d_tab[((k / 4) + 1) % 4]);
            chk($sformatf("scan%0d_wrap", k), wrap_a, (k == 12 || k == 28) ? 1'b1 : 1'b0);
            chk($sformatf("scan%0d_valid", k), valid_a, 1'b1);
        end

        // Freeze for 5 clocks just after a wrap
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("frz%0d_d", k), d_a, 4'b0001);
            chk($sformatf("frz%0d_idx", k), idx_a, 2'd0);
            chk($sformatf("frz%0d_wrap", k), wrap_a, 1'b0);
        end
        en = 1'b1;
        step(); step(); step();
        chk("unfrz_hold_d", d_a, 4'b0001);
        step();
        chk("unfrz_step_d", d_a, 4'b0010);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_d",     d_a, 4'b0000);
        chk("arst_valid", valid_a, 1'b0);
        chk("arst_idx",   idx_a, 2'd0);
        mode_a = 2'b00;
        step();
        rst_n = 1'b1;
        step();

        // ONESHOT from sel=0, 2-cycle dwell
        mode_b = 2'b11; sel_b = 2'd0;
        step();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk($sformatf("one%0d_d", k), d_b, d_tab[k / 2]);
            chk($sformatf("one%0d_done", k), done_b, 1'b0);
        end
        step();
        chk("one_end_d",     d_b, 4'b0000);
        chk("one_end_valid", valid_b, 1'b0);
        chk("one_end_done",  done_b, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("one_hold%0d_done", k), done_b, 1'b1);
            chk($sformatf("one_hold%0d_d", k), d_b, 4'b0000);
        end
        mode_b = 2'b00;
        step();
        chk("one_idle_done", done_b, 1'b0);
        mode_b = 2'b11;
        step();
        chk("one_re_d",     d_b, 4'b0001);
        chk("one_re_valid", valid_b, 1'b1);
        chk("one_re_done",  done_b, 1'b0);

        // Single dwell from the last index
        mode_b = 2'b00;
        step();
        mode_b = 2'b11; sel_b = 2'd3;
        step();
        chk("one3_d0", d_b, 4'b1000);
        step();
        chk("one3_d1", d_b, 4'b1000);
        step();
        chk("one3_done", done_b, 1'b1);
        chk("one3_d",    d_b, 4'b0000);

        // SEL_W=3, SCAN_DIV=1
        mode_c = 2'b10; sel_c = 3'd0;
        step();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            chk($sformatf("c%0d_idx", k), idx_c, 32'(k % 8));
            chk($sformatf("c%0d_d", k), d_c, 32'(1) << (k % 8));
            chk($sformatf("c%0d_wrap", k), wrap_c, (k == 8 || k == 16) ? 1'b1 : 1'b0);
            chk($sformatf("c%0d_inv", k), valid_c, (d_c == (8'd1 << idx_c)) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
